// File: rtl/edge_latency_meter_pkg.sv
// Shared types and helpers for the edge latency meter: FSM state encoding
// and the 8-bit saturating counter increment used for the run statistics.
package edge_latency_pkg;

  localparam int CNT8 = 8;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  function automatic logic [CNT8-1:0] sat_inc8(input logic [CNT8-1:0] v);
    return (v == {CNT8{1'b1}}) ? v : v + CNT8'(1);
  endfunction

endpackage

// File: rtl/edge_latency_meter_sync_rise.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Pin-to-pulse delay is three clocks, identical for every instance.
module sync_rise (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1, r_s2, r_s3, r_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/edge_latency_meter.sv
// Measures stimulus-rise to response-rise latency in clk cycles over a run
// of SAMPLES pulses, accumulating last/min/max/sum and timeout/overrun counts.
module edge_latency_meter
  import edge_latency_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SAMPLES = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stim,
  input  logic               resp,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   last_lat,
  output logic [WIDTH-1:0]   min_lat,
  output logic [WIDTH-1:0]   max_lat,
  output logic [WIDTH+7:0]   sum_lat,
  output logic [CNT8-1:0]    n_good,
  output logic [CNT8-1:0]    n_timeout,
  output logic [CNT8-1:0]    n_overrun
);

  localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  function automatic logic [WIDTH+7:0] sat_add_sum(input logic [WIDTH+7:0] acc,
                                                   input logic [WIDTH-1:0] lat);
    logic [WIDTH+8:0] wide;
    wide = {1'b0, acc} + {9'd0, lat};
    return wide[WIDTH+8] ? {(WIDTH+8){1'b1}} : wide[WIDTH+7:0];
  endfunction

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_lat, w_lat_rec;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_last, r_min, r_max;
  logic [WIDTH+7:0] r_sum;
  logic [CNT8-1:0]  r_good, r_tmo, r_ovr;
  logic             w_stim_rise, w_resp_rise;
  logic             w_clear, w_good, w_tmo, w_ovr, w_load, w_last_idx;

  sync_rise u_sync_stim (.clk(clk), .reset_n(reset_n), .i_async(stim), .o_rise(w_stim_rise));
  sync_rise u_sync_resp (.clk(clk), .reset_n(reset_n), .i_async(resp), .o_rise(w_resp_rise));

  // The count "in this cycle" is one past the register, so a response one
  // cycle after the stimulus edge reads as latency 1.
  assign w_lat      = r_cnt + WIDTH'(1);
  assign w_last_idx = (r_idx == IDX_W'(SAMPLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_good      = 1'b0;
    w_tmo       = 1'b0;
    w_ovr       = 1'b0;
    w_load      = 1'b0;
    w_lat_rec   = '0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        if (w_stim_rise) begin
          if (w_resp_rise) begin
            w_good = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = MEASURE;
          end
        end
      end
      MEASURE: begin
        if (w_resp_rise) begin
          w_good    = 1'b1;
          w_lat_rec = w_lat;
        end else begin
          w_tmo = (w_lat == WIDTH'(TIMEOUT - 1));
          w_ovr = w_stim_rise;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_good || w_tmo) w_state_nxt = w_last_idx ? DONE : ARM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_last <= '0;
      r_min  <= '1;
      r_max  <= '0;
      r_sum  <= '0;
      r_good <= '0;
      r_tmo  <= '0;
      r_ovr  <= '0;
    end else if (w_clear) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_last <= '0;
      r_min  <= '1;
      r_max  <= '0;
      r_sum  <= '0;
      r_good <= '0;
      r_tmo  <= '0;
      r_ovr  <= '0;
    end else begin
      if (w_load)                  r_cnt <= '0;
      else if (r_state == MEASURE) r_cnt <= w_lat;
      if (w_good) begin
        r_last <= w_lat_rec;
        if (w_lat_rec < r_min) r_min <= w_lat_rec;
        if (w_lat_rec > r_max) r_max <= w_lat_rec;
        r_sum  <= sat_add_sum(r_sum, w_lat_rec);
        r_good <= sat_inc8(r_good);
      end
      if (w_tmo)          r_tmo <= sat_inc8(r_tmo);
      if (w_ovr)          r_ovr <= sat_inc8(r_ovr);
      if (w_good || w_tmo) r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign busy      = (r_state == ARM) || (r_state == MEASURE);
  assign done      = (r_state == DONE);
  assign last_lat  = r_last;
  assign min_lat   = r_min;
  assign max_lat   = r_max;
  assign sum_lat   = r_sum;
  assign n_good    = r_good;
  assign n_timeout = r_tmo;
  assign n_overrun = r_ovr;

endmodule

// File: tb/tb_edge_latency_meter.sv
// Directed bench: a 3-sample instance for functional cases and a narrow
// 300-sample instance for counter and sum saturation.
module tb_edge_latency_meter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stim = 1'b0;
  logic resp = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        busy_a, done_a;
  logic [31:0] last_a, min_a, max_a;
  logic [39:0] sum_a;
  logic [7:0]  good_a, tmo_a, ovr_a;

  logic        busy_b, done_b;
  logic [4:0]  last_b, min_b, max_b;
  logic [12:0] sum_b;
  logic [7:0]  good_b, tmo_b, ovr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_latency_meter #(.WIDTH(32), .SAMPLES(3), .TIMEOUT(20)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .stim(stim), .resp(resp), .start(start_a),
    .busy(busy_a), .done(done_a), .last_lat(last_a), .min_lat(min_a),
    .max_lat(max_a), .sum_lat(sum_a), .n_good(good_a), .n_timeout(tmo_a),
    .n_overrun(ovr_a)
  );

  edge_latency_meter #(.WIDTH(5), .SAMPLES(300), .TIMEOUT(30)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .stim(stim), .resp(resp), .start(start_b),
    .busy(busy_b), .done(done_b), .last_lat(last_b), .min_lat(min_b),
    .max_lat(max_b), .sum_lat(sum_b), .n_good(good_b), .n_timeout(tmo_b),
    .n_overrun(ovr_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lat < 0: no response. extra > 0: second stim pulse starting at that cycle.
  task automatic pulse(input int lat, input int extra);
    int n;
    n = (lat < 0) ? 32 : lat + 9;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      stim = (c < 3) || (extra > 0 && c >= extra && c < extra + 3);
      resp = (lat >= 0) && (c >= lat) && (c < lat + 3);
    end
  endtask

  task automatic kick_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_last"}, last_a, 0);
    check({tag, "_min"},  min_a, 64'hFFFF_FFFF);
    check({tag, "_max"},  max_a, 0);
    check({tag, "_sum"},  sum_a, 0);
    check({tag, "_good"}, good_a, 0);
    check({tag, "_tmo"},  tmo_a, 0);
    check({tag, "_ovr"},  ovr_a, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_a("rst");
    check("rst_b_min", min_b, 5'h1F);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Equal latencies of 5
    kick_a();
    check("start_busy", busy_a, 1);
    pulse(5, 0); pulse(5, 0); pulse(5, 0);
    check("eq_good", good_a, 3);
    check("eq_last", last_a, 5);
    check("eq_min",  min_a, 5);
    check("eq_max",  max_a, 5);
    check("eq_sum",  sum_a, 15);
    check("eq_done", done_a, 1);
    check("eq_busy", busy_a, 0);

    // Mixed latencies; restart from DONE clears done
    kick_a();
    check("restart_done", done_a, 0);
    check("restart_good", good_a, 0);
    pulse(2, 0); pulse(9, 0); pulse(4, 0);
    check("mix_min",  min_a, 2);
    check("mix_max",  max_a, 9);
    check("mix_last", last_a, 4);
    check("mix_sum",  sum_a, 15);

    // Timeout on the second sample
    kick_a();
    pulse(6, 0); pulse(-1, 0); pulse(7, 0);
    check("to_tmo",  tmo_a, 1);
    check("to_good", good_a, 2);
    check("to_min",  min_a, 6);
    check("to_max",  max_a, 7);
    check("to_sum",  sum_a, 13);
    check("to_last", last_a, 7);
    check("to_done", done_a, 1);

    // Coincident edges and an overrun stim
    kick_a();
    pulse(0, 0);
    check("zero_last", last_a, 0);
    check("zero_busy", busy_a, 1);
    pulse(12, 5); pulse(3, 0);
    check("ovr_ovr",  ovr_a, 1);
    check("ovr_max",  max_a, 12);
    check("ovr_min",  min_a, 0);
    check("ovr_sum",  sum_a, 15);
    check("ovr_good", good_a, 3);
    check("ovr_done", done_a, 1);

    // start mid-run is ignored, then reset lands inside MEASURE
    kick_a();
    pulse(5, 0);
    kick_a();
    check("ign_good", good_a, 1);
    check("ign_busy", busy_a, 1);
    @(negedge clk); stim = 1'b1;
    repeat (3) @(negedge clk); stim = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_a("midrst");
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    kick_a();
    pulse(4, 0); pulse(4, 0); pulse(4, 0);
    check("post_good", good_a, 3);
    check("post_sum",  sum_a, 12);
    check("post_done", done_a, 1);

    // 300 samples of latency 28 on the narrow instance
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 300; i++) pulse(28, 0);
    check("sat_good", good_b, 255);
    check("sat_sum",  sum_b, 13'h1FFF);
    check("sat_max",  max_b, 28);
    check("sat_min",  min_b, 28);
    check("sat_tmo",  tmo_b, 0);
    check("sat_done", done_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
